// File: rtl/alu_pkg.sv
// alu_pkg: alu_op code space shared by the ALU control decoder and the execute stage.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_BEQ  = 4'b1000,
    ALU_BNE  = 4'b1001,
    ALU_BLT  = 4'b1010,
    ALU_BGE  = 4'b1011,
    ALU_BLTU = 4'b1100,
    ALU_BGEU = 4'b1101
  } alu_op_e;

  function automatic logic is_branch(input logic [3:0] op);
    return op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU and branch comparator; undefined codes flag illegal and yield zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);
  always_comb begin
    result       = '0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (alu_op)
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_BEQ:  branch_taken = op_a == op_b;
      ALU_BNE:  branch_taken = op_a != op_b;
      ALU_BLT:  branch_taken = $signed(op_a) < $signed(op_b);
      ALU_BGE:  branch_taken = $signed(op_a) >= $signed(op_b);
      ALU_BLTU: branch_taken = op_a < op_b;
      ALU_BGEU: branch_taken = op_a >= op_b;
      default:  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_execute_stage.sv
// alu_execute_stage: registered execute stage with valid/ready output register and sync flush.
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_wr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             branch_taken,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wr
);
  logic [XLEN-1:0]  core_res, result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             core_taken, core_ill, accept;
  logic             valid_q, valid_d, taken_q, taken_d, ill_q, ill_d, wr_q, wr_d;

  alu_core #(.XLEN(XLEN)) u_core (
    .alu_op       (alu_op),
    .op_a         (op_a),
    .op_b         (op_b),
    .result       (core_res),
    .branch_taken (core_taken),
    .illegal      (core_ill)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush only kills validity and the write enable; data fields may stay stale.
  always_comb begin
    valid_d  = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
    result_d = accept ? core_res : result_q;
    taken_d  = accept ? core_taken : taken_q;
    ill_d    = accept ? core_ill : ill_q;
    tag_d    = accept ? in_tag : tag_q;
    wr_d     = flush ? 1'b0 : accept ? in_wr && !core_ill && !is_branch(alu_op) : wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      taken_q  <= 1'b0;
      ill_q    <= 1'b0;
      tag_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      ill_q    <= ill_d;
      tag_q    <= tag_d;
      wr_q     <= wr_d;
    end
  end

  assign out_valid    = valid_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign zero         = result_q == '0;
  assign illegal      = ill_q;
  assign out_tag      = tag_q;
  assign out_wr       = wr_q;
endmodule

// File: tb/tb_alu_execute_stage.sv
// tb_alu_execute_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_alu_execute_stage;
  import alu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_wr = 1'b0, flush = 1'b0;
  logic        out_valid, out_ready = 1'b1, branch_taken, zero, illegal, out_wr;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic [4:0]  in_tag = '0, out_tag;
  int          vectors = 0, miscompares = 0;
  logic        chk_en = 1'b0;

  logic        m_valid, m_taken, m_ill, m_wr;
  logic [31:0] m_res;
  logic [4:0]  m_tag;

  alu_execute_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .in_tag(in_tag), .in_wr(in_wr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .zero(zero), .illegal(illegal),
    .out_tag(out_tag), .out_wr(out_wr)
  );

  always #5 clk = ~clk;

  // Reference: {illegal, taken, result} straight from the operation table.
  function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'b0000: return {2'b00, a & b};
      4'b0001: return {2'b00, a | b};
      4'b0010: return {2'b00, 32'(a + b)};
      4'b0110: return {2'b00, 32'(a - b)};
      4'b1000: return {1'b0, a == b, 32'd0};
      4'b1001: return {1'b0, a != b, 32'd0};
      4'b1010: return {1'b0, sa < sb, 32'd0};
      4'b1011: return {1'b0, sa >= sb, 32'd0};
      4'b1100: return {1'b0, a < b, 32'd0};
      4'b1101: return {1'b0, a >= b, 32'd0};
      default: return {1'b1, 1'b0, 32'd0};
    endcase
  endfunction

  function automatic logic writes(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_res <= '0; m_taken <= 1'b0; m_ill <= 1'b0; m_tag <= '0; m_wr <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_wr    <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      {m_ill, m_taken, m_res} <= ref_alu(alu_op, op_a, op_b);
      m_tag   <= in_tag;
      m_wr    <= in_wr && writes(alu_op);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("result", result, m_res);
        chk("branch_taken", 32'(branch_taken), 32'(m_taken));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("zero", 32'(zero), 32'(m_res == 0));
        chk("out_tag", 32'(out_tag), 32'(m_tag));
        chk("out_wr", 32'(out_wr), 32'(m_wr));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic wr);
    @(posedge clk); #1;
    chk("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b; in_tag = tag; in_wr = wr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(3))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(7)) | (($urandom_range(1) == 1) ? 32'h8000_0000 : 32'h0);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic take, hold;
    logic [3:0] ops [10];
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};

    chk("model_sub", ref_alu(4'b0110, 32'd5, 32'd7), {2'b00, 32'hFFFF_FFFE});
    chk("model_blt", ref_alu(4'b1010, 32'hFFFF_FFFF, 32'd1), {2'b01, 32'd0});
    chk("model_bltu", ref_alu(4'b1100, 32'hFFFF_FFFF, 32'd1), {2'b00, 32'd0});
    chk("model_ill", ref_alu(4'b0111, 32'd3, 32'd4), {2'b10, 32'd0});

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_out_wr", 32'(out_wr), 32'd0);

    send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1);
    chk("add_result", result, 32'd0);
    chk("add_zero", 32'(zero), 32'd1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_wr", 32'(out_wr), 32'd1);
    send(ALU_SUB, 32'd5, 32'd7, 5'd4, 1'b1);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(zero), 32'd0);
    send(ALU_AND, 32'hF0F0, 32'hFF00, 5'd5, 1'b1);
    chk("and_result", result, 32'hF000);
    send(ALU_OR, 32'hF0F0, 32'hFF00, 5'd6, 1'b1);
    chk("or_result", result, 32'hFFF0);
    send(ALU_BLT, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);
    chk("blt_taken", 32'(branch_taken), 32'd1);
    chk("blt_wr", 32'(out_wr), 32'd0);
    chk("blt_result", result, 32'd0);
    send(ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1);
    chk("bltu_taken", 32'(branch_taken), 32'd0);
    chk("bltu_wr", 32'(out_wr), 32'd0);
    send(ALU_BGEU, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1);
    chk("bgeu_taken", 32'(branch_taken), 32'd1);
    chk("bgeu_wr", 32'(out_wr), 32'd0);
    send(4'b0111, 32'd9, 32'd9, 5'd10, 1'b1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_result", result, 32'd0);
    chk("ill_wr", 32'(out_wr), 32'd0);

    send(ALU_ADD, 32'd1, 32'd2, 5'd1, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = ALU_ADD; op_a = 32'd10; op_b = 32'd20; in_tag = 5'd2; in_wr = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd3);
      chk("bp_tag", 32'(out_tag), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_result", result, 32'd30);
    chk("bp_next_tag", 32'(out_tag), 32'd2);
    @(posedge clk); #1;
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    send(ALU_OR, 32'd1, 32'd2, 5'd11, 1'b1);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; alu_op = ALU_ADD; op_a = 32'd7; op_b = 32'd8; in_tag = 5'd12; flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_wr", 32'(out_wr), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl_dropped", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    send(ALU_ADD, 32'd4, 32'd4, 5'd13, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_zero", 32'(zero), 32'd1);
    chk("ar_wr", 32'(out_wr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;

    chk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      take = in_valid && in_ready && !flush;
      hold = in_valid && !take && !flush;
      @(posedge clk); #1;
      out_ready = $urandom_range(3) != 0;
      flush = $urandom_range(15) == 0;
      if (!hold) begin
        in_valid = $urandom_range(3) != 0;
        alu_op = ($urandom_range(7) == 0) ? 4'($urandom) : ops[$urandom_range(9)];
        op_a = rnd_opnd();
        op_b = ($urandom_range(3) == 0) ? op_a : rnd_opnd();
        in_tag = 5'($urandom);
        in_wr = 1'($urandom);
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Registered execute stage that sits directly downstream of the ALU control decoder. Consumes its 4-bit operation code with two operands, computes the arithmetic/logic result or branch decision, and holds it in an output register behind a valid/ready handshake so the memory stage can stall it. Supports a synchronous flush for branch mispredicts and traps.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `TAG_W`, 5: width of the destination-register tag carried alongside the data.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: upstream presents an operation.
- `in_ready` output 1: stage can accept this cycle.
- `alu_op` input 4: operation code from the ALU control decoder.
- `op_a`, `op_b` input XLEN: operands.
- `in_tag` input TAG_W: destination register index, passed through.
- `in_wr` input 1: register-write enable, passed through.
- `flush` input 1: discard held and incoming operation.
- `out_valid` output 1: result register holds a live operation.
- `out_ready` input 1: downstream consumes this cycle.
- `result` output XLEN: computed value.
- `branch_taken` output 1: branch condition true (branch codes only).
- `zero` output 1: `result == 0`.
- `illegal` output 1: `alu_op` was not a defined code.
- `out_tag` output TAG_W, `out_wr` output 1: registered pass-through.

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 BEQ, 1001 BNE, 1010 BLT (signed), 1011 BGE (signed), 1100 BLTU, 1101 BGEU.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- Branch codes: `result` = 0, `branch_taken` = compare outcome, `out_wr` forced 0.
- Non-branch codes: `branch_taken` = 0.
- Undefined code (any other value): `result` = 0, `branch_taken` = 0, `out_wr` forced 0, `illegal` = 1.
- `zero` is computed from the registered `result`.
- Accept = `in_valid && in_ready && !flush`. `in_ready` = `!out_valid || out_ready` (combinational, independent of `in_valid`).
- On accept, all output fields load and `out_valid` sets. On `out_ready && out_valid` without a new accept, `out_valid` clears. Simultaneous consume and accept gives back-to-back throughput.
- While `out_valid && !out_ready`, all outputs hold stable.

## Timing
- Latency: 1 cycle from the accepting edge to `out_valid`. Throughput: 1 operation per cycle when `out_ready` is high.
- Reset (async assert, sync release to `clk`): `out_valid` = 0, `result` = 0, `branch_taken` = 0, `zero` = 1, `illegal` = 0, `out_tag` = 0, `out_wr` = 0. `in_ready` = 1 immediately.
- `flush` is synchronous. At the next edge `out_valid` = 0 and the incoming operation is dropped. Flush takes priority over accept and over hold. Data fields may retain stale values but `out_wr` clears.
- Reset asserted mid-stall drops the held operation. No partial state survives.
- `in_ready` falls only when `out_valid && !out_ready`. Upstream must hold `in_valid` and its data until accepted.

## Structure
- Shared package (`alu_pkg`): the 4-bit `alu_op` encodings as named constants (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_BEQ` … `ALU_BGEU`), shared with the ALU control decoder so both blocks agree on the code space.
- One combinational sub-module, `alu_core`: takes `alu_op`, `op_a`, `op_b`; produces `result`, `branch_taken`, `illegal`.
- The top level holds only the handshake and output register.

## Test plan
- After reset, check idle outputs: `in_ready` = 1, `out_valid` = 0, `zero` = 1.
- ADD with a = 0xFFFFFFFF, b = 1 -> next cycle `result` = 0, `zero` = 1, `out_valid` = 1.
- SUB with a = 5, b = 7 -> `result` = 0xFFFFFFFE.
- AND with a = 0xF0F0, b = 0xFF00 -> 0xF000.
- OR with a = 0xF0F0, b = 0xFF00 -> 0xFFF0.
- Signed vs. unsigned branch with a = 0xFFFFFFFF, b = 1:
  - BLT -> `branch_taken` = 1.
  - BLTU -> `branch_taken` = 0.
  - BGEU -> `branch_taken` = 1.
  - In all three cases `out_wr` = 0.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 and a new op. Required: `in_ready` = 0, outputs stable. Then raise `out_ready`: the held op is consumed and the new op appears the next cycle with no loss or duplication.
- Flush while `out_valid` = 1 and `in_valid` = 1 -> next cycle `out_valid` = 0, `out_wr` = 0, incoming op not delivered.
- `alu_op` = 0111 with `in_wr` = 1 -> `illegal` = 1, `result` = 0, `out_wr` = 0.
